// File: rtl/thread_pkg.sv
// Shared thread-count constants and types for the barrel-pipeline thread logic.
// Any block that indexes or masks hardware threads imports this package.
package thread_pkg;

  localparam int NUM_THREADS       = 8;
  localparam int THREAD_INDEX_BITS = 3;

  typedef logic [NUM_THREADS-1:0]       thread_mask_t;
  typedef logic [THREAD_INDEX_BITS-1:0] thread_idx_t;

  function automatic thread_mask_t idx_to_onehot(input thread_idx_t idx);
    return thread_mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: returns the first requester found searching
// upward from ptr+1, wrapping. N must be a power of two.
module rr_priority_picker #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_index
);

  logic [IW-1:0]  start;
  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IW-1:0]  offset;

  // start wraps naturally because N is a power of two
  assign start   = ptr + IW'(1);
  assign doubled = {req, req};
  assign rotated = doubled[start +: N];

  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = IW'(i);
      end
    end
  end

  assign grant_valid = |req;
  assign grant_index = offset + start;

endmodule

// File: rtl/thread_fetch_scheduler.sv
// Chooses the hardware thread the fetch stage issues from each cycle, round-robin
// over threads that are active and not blocked, honouring fetch back-pressure.
module thread_fetch_scheduler
  import thread_pkg::*;
#(
  parameter int           BLOCK_CNT_BITS    = 4,
  parameter thread_mask_t RESET_ACTIVE_MASK = 8'h01
) (
  input  logic                      clk,
  input  logic                      reset,
  input  thread_mask_t              thread_enable_set,
  input  thread_mask_t              thread_enable_clr,
  input  logic                      block_valid,
  input  thread_idx_t               block_thread_index,
  input  logic [BLOCK_CNT_BITS-1:0] block_cycles,
  input  logic                      fetch_stall,
  output logic                      out_fetch_valid,
  output thread_idx_t               out_thread_index,
  output thread_mask_t              out_active_mask,
  output thread_mask_t              out_ready_mask
);

  thread_mask_t                active_mask;
  logic [BLOCK_CNT_BITS-1:0]   block_cnt [NUM_THREADS];
  thread_idx_t                 rr_ptr;
  logic                        fetch_valid_q;
  thread_idx_t                 thread_index_q;

  thread_mask_t                block_vec;
  thread_mask_t                ready_mask;
  thread_mask_t                elig_mask;
  logic                        grant_valid;
  thread_idx_t                 grant_index;

  always_comb begin
    block_vec = '0;
    if (block_valid && (block_cycles != '0)) begin
      block_vec = idx_to_onehot(block_thread_index);
    end
  end

  always_comb begin
    ready_mask = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      ready_mask[i] = active_mask[i] && (block_cnt[i] == '0);
    end
  end

  // A clear or block requested this cycle already keeps the thread out of this edge's pick
  assign elig_mask = ready_mask & ~thread_enable_clr & ~block_vec;

  rr_priority_picker #(
    .N  (NUM_THREADS),
    .IW (THREAD_INDEX_BITS)
  ) u_picker (
    .req         (elig_mask),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_index (grant_index)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      active_mask <= RESET_ACTIVE_MASK;
    end else begin
      active_mask <= (active_mask | thread_enable_set) & ~thread_enable_clr;
    end
  end

  // A fresh block load replaces any count in progress and skips that edge's decrement
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (reset) begin
        block_cnt[i] <= '0;
      end else if (block_vec[i]) begin
        block_cnt[i] <= block_cycles;
      end else if (block_cnt[i] != '0) begin
        block_cnt[i] <= block_cnt[i] - BLOCK_CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr         <= thread_idx_t'(NUM_THREADS - 1);
      fetch_valid_q  <= 1'b0;
      thread_index_q <= '0;
    end else if (!fetch_stall) begin
      if (grant_valid) begin
        fetch_valid_q  <= 1'b1;
        thread_index_q <= grant_index;
        rr_ptr         <= grant_index;
      end else begin
        fetch_valid_q  <= 1'b0;
      end
    end
  end

  assign out_fetch_valid  = fetch_valid_q;
  assign out_thread_index = thread_index_q;
  assign out_active_mask  = active_mask;
  assign out_ready_mask   = ready_mask;

endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Self-checking bench for thread_fetch_scheduler: directed vector table plus
// randomized traffic compared against a behavioural thread-scheduling model.
module tb_thread_fetch_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] thread_enable_set;
  logic [7:0] thread_enable_clr;
  logic       block_valid;
  logic [2:0] block_thread_index;
  logic [3:0] block_cycles;
  logic       fetch_stall;
  logic       out_fetch_valid;
  logic [2:0] out_thread_index;
  logic [7:0] out_active_mask;
  logic [7:0] out_ready_mask;

  int passCount  = 0;
  int checkCount = 0;

  thread_fetch_scheduler dut (
    .clk                (clk),
    .reset              (reset),
    .thread_enable_set  (thread_enable_set),
    .thread_enable_clr  (thread_enable_clr),
    .block_valid        (block_valid),
    .block_thread_index (block_thread_index),
    .block_cycles       (block_cycles),
    .fetch_stall        (fetch_stall),
    .out_fetch_valid    (out_fetch_valid),
    .out_thread_index   (out_thread_index),
    .out_active_mask    (out_active_mask),
    .out_ready_mask     (out_ready_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] set;
    logic [7:0] clr;
    logic       bv;
    logic [2:0] bi;
    logic [3:0] bc;
    logic       stall;
    logic       expValid;
    logic [2:0] expIdx;
    logic [7:0] expMask;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: per-thread flags and countdowns, plain wrap-around search
  bit mActive[8];
  int mCnt[8];
  int mRr;
  bit mValid;
  int mIdx;

  task automatic modelStep(input logic rst, input logic [7:0] set, input logic [7:0] clr,
                           input logic bv, input logic [2:0] bi, input logic [3:0] bc,
                           input logic stall);
    bit blk[8];
    bit elig[8];
    int winner;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        mActive[i] = (i == 0);
        mCnt[i]    = 0;
      end
      mRr = 7; mValid = 0; mIdx = 0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      blk[i]  = bv && (bc != 0) && (int'(bi) == i);
      elig[i] = mActive[i] && (mCnt[i] == 0) && !clr[i] && !blk[i];
    end
    winner = -1;
    for (int k = 1; k <= 8; k++) begin
      if (winner < 0 && elig[(mRr + k) % 8]) winner = (mRr + k) % 8;
    end
    if (!stall) begin
      if (winner >= 0) begin
        mValid = 1; mIdx = winner; mRr = winner;
      end else begin
        mValid = 0;
      end
    end
    for (int i = 0; i < 8; i++) begin
      mActive[i] = (mActive[i] || set[i]) && !clr[i];
      if (blk[i]) mCnt[i] = int'(bc);
      else if (mCnt[i] > 0) mCnt[i] = mCnt[i] - 1;
    end
  endtask

  function automatic logic [7:0] modelMask();
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = mActive[i];
    return m;
  endfunction

  function automatic logic [7:0] modelReady();
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = mActive[i] && (mCnt[i] == 0);
    return m;
  endfunction

  task automatic checkField(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [2:0] ei,
                             input logic [7:0] em, input logic [7:0] er);
    checkField({tag, ".valid"}, int'(out_fetch_valid), int'(ev));
    checkField({tag, ".index"}, int'(out_thread_index), int'(ei));
    checkField({tag, ".active"}, int'(out_active_mask), int'(em));
    checkField({tag, ".ready"}, int'(out_ready_mask), int'(er));
  endtask

  task automatic applyStimulus(input logic rst, input logic [7:0] set, input logic [7:0] clr,
                               input logic bv, input logic [2:0] bi, input logic [3:0] bc,
                               input logic stall);
    reset = rst; thread_enable_set = set; thread_enable_clr = clr;
    block_valid = bv; block_thread_index = bi; block_cycles = bc; fetch_stall = stall;
    @(posedge clk);
    modelStep(rst, set, clr, bv, bi, bc, stall);
    #1;
  endtask

  task automatic addVec(input logic rst, input logic [7:0] set, input logic [7:0] clr,
                        input logic bv, input logic [2:0] bi, input logic [3:0] bc,
                        input logic stall, input logic ev, input logic [2:0] ei,
                        input logic [7:0] em);
    vec_t v;
    v.rst = rst; v.set = set; v.clr = clr; v.bv = bv; v.bi = bi; v.bc = bc;
    v.stall = stall; v.expValid = ev; v.expIdx = ei; v.expMask = em;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic ev, input logic [2:0] ei, input logic [7:0] em);
    addVec(0, 8'h00, 8'h00, 0, 3'd0, 4'd0, 0, ev, ei, em);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset and single default thread
    addVec(1, 8'h00, 8'h00, 0, 3'd0, 4'd0, 0, 0, 3'd0, 8'h01);
    addVec(1, 8'h00, 8'h00, 0, 3'd0, 4'd0, 0, 0, 3'd0, 8'h01);
    idle(1, 3'd0, 8'h01);
    idle(1, 3'd0, 8'h01);
    // All threads on, full rotation, then drop thread 4
    addVec(0, 8'hFF, 8'h00, 0, 3'd0, 4'd0, 0, 1, 3'd0, 8'hFF);
    for (int i = 1; i <= 8; i++) idle(1, 3'(i % 8), 8'hFF);
    for (int i = 1; i <= 3; i++) idle(1, 3'(i), 8'hFF);
    addVec(0, 8'h00, 8'h10, 0, 3'd0, 4'd0, 0, 1, 3'd5, 8'hEF);
    idle(1, 3'd6, 8'hEF); idle(1, 3'd7, 8'hEF); idle(1, 3'd0, 8'hEF);
    idle(1, 3'd1, 8'hEF); idle(1, 3'd2, 8'hEF); idle(1, 3'd3, 8'hEF);
    idle(1, 3'd5, 8'hEF);
    // Threads {0,1}: block thread 1 for 3, then reblock 3 -> 5
    addVec(0, 8'h00, 8'hFC, 0, 3'd0, 4'd0, 0, 1, 3'd0, 8'h03);
    idle(1, 3'd1, 8'h03); idle(1, 3'd0, 8'h03);
    addVec(0, 8'h00, 8'h00, 1, 3'd1, 4'd3, 0, 1, 3'd0, 8'h03);
    for (int i = 0; i < 3; i++) idle(1, 3'd0, 8'h03);
    idle(1, 3'd1, 8'h03); idle(1, 3'd0, 8'h03); idle(1, 3'd1, 8'h03); idle(1, 3'd0, 8'h03);
    addVec(0, 8'h00, 8'h00, 1, 3'd1, 4'd3, 0, 1, 3'd0, 8'h03);
    addVec(0, 8'h00, 8'h00, 1, 3'd1, 4'd5, 0, 1, 3'd0, 8'h03);
    for (int i = 0; i < 5; i++) idle(1, 3'd0, 8'h03);
    idle(1, 3'd1, 8'h03); idle(1, 3'd0, 8'h03);
    // Nothing eligible: valid drops, index holds, regrant after expiry
    addVec(0, 8'h00, 8'h01, 0, 3'd0, 4'd0, 0, 1, 3'd1, 8'h02);
    addVec(0, 8'h00, 8'h00, 1, 3'd1, 4'd2, 0, 0, 3'd1, 8'h02);
    idle(0, 3'd1, 8'h02); idle(0, 3'd1, 8'h02); idle(1, 3'd1, 8'h02);
    // Stall for three cycles holding index 2, block thread 5 meanwhile
    addVec(0, 8'hFF, 8'h00, 0, 3'd0, 4'd0, 0, 1, 3'd1, 8'hFF);
    idle(1, 3'd2, 8'hFF);
    addVec(0, 8'h00, 8'h00, 1, 3'd5, 4'd2, 1, 1, 3'd2, 8'hFF);
    addVec(0, 8'h00, 8'h00, 0, 3'd0, 4'd0, 1, 1, 3'd2, 8'hFF);
    addVec(0, 8'h00, 8'h00, 0, 3'd0, 4'd0, 1, 1, 3'd2, 8'hFF);
    idle(1, 3'd3, 8'hFF); idle(1, 3'd4, 8'hFF); idle(1, 3'd5, 8'hFF);
    // Set and clear of thread 3 together: clear wins
    addVec(0, 8'h08, 8'h08, 0, 3'd0, 4'd0, 0, 1, 3'd6, 8'hF7);
    idle(1, 3'd7, 8'hF7); idle(1, 3'd0, 8'hF7); idle(1, 3'd1, 8'hF7);
    idle(1, 3'd2, 8'hF7); idle(1, 3'd4, 8'hF7);
    // Reset while thread 6 is blocked
    addVec(0, 8'h00, 8'h00, 1, 3'd6, 4'd9, 0, 1, 3'd5, 8'hF7);
    idle(1, 3'd7, 8'hF7);
    addVec(1, 8'hFF, 8'h00, 1, 3'd2, 4'd4, 0, 0, 3'd0, 8'h01);
    addVec(0, 8'h40, 8'h00, 0, 3'd0, 4'd0, 0, 1, 3'd0, 8'h41);
    idle(1, 3'd6, 8'h41); idle(1, 3'd0, 8'h41);

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].rst, vecs[n].set, vecs[n].clr, vecs[n].bv,
                    vecs[n].bi, vecs[n].bc, vecs[n].stall);
      checkOutput($sformatf("vec%0d", n), vecs[n].expValid, vecs[n].expIdx,
                  vecs[n].expMask, modelReady());
    end

    // Randomized traffic against the model
    applyStimulus(1, 8'h00, 8'h00, 0, 3'd0, 4'd0, 0);
    checkOutput("rnd_reset", mValid, 3'(mIdx), modelMask(), modelReady());
    for (int n = 0; n < 600; n++) begin
      logic       rst;
      logic [7:0] set;
      logic [7:0] clr;
      logic       bv;
      rst = ($urandom_range(0, 99) == 0);
      set = ($urandom_range(0, 3) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
      clr = ($urandom_range(0, 4) == 0) ? 8'($urandom) & 8'($urandom) & 8'($urandom) : 8'h00;
      bv  = ($urandom_range(0, 3) == 0);
      applyStimulus(rst, set, clr, bv, 3'($urandom), 4'($urandom_range(0, 6)),
                    ($urandom_range(0, 4) == 0));
      checkOutput($sformatf("rnd%0d", n), mValid, 3'(mIdx), modelMask(), modelReady());
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/thread_fetch_scheduler.md
# thread_fetch_scheduler

- Picks which hardware thread the fetch stage issues from each cycle in the multithreaded (barrel) pipeline.
- Uses round-robin arbitration over threads that are both active and not blocked.
- Drives the thread index that enters the fetch/decode pipeline registers.
- Tracks per-thread active state and per-thread block countdowns (long-latency ops, branch resolution), and honours back-pressure from fetch.

## Interface
- NUM_THREADS, 8, number of hardware threads (power of two)
- THREAD_INDEX_BITS, 3, log2(NUM_THREADS)
- BLOCK_CNT_BITS, 4, width of per-thread block counter
- RESET_ACTIVE_MASK, 8'h01, active mask loaded at reset

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- thread_enable_set  in  NUM_THREADS  per-thread activate pulse
- thread_enable_clr  in  NUM_THREADS  per-thread deactivate pulse
- block_valid  in  1  block request this cycle
- block_thread_index  in  THREAD_INDEX_BITS  thread to block
- block_cycles  in  BLOCK_CNT_BITS  block length K; 0 = no-op
- fetch_stall  in  1  fetch cannot accept a new selection this cycle
- out_fetch_valid  out  1  registered: selection valid
- out_thread_index  out  THREAD_INDEX_BITS  registered: selected thread
- out_active_mask  out  NUM_THREADS  registered active mask
- out_ready_mask  out  NUM_THREADS  combinational: active & unblocked, before this cycle's updates

## Operation
- **State:**
  - active_mask[N]
  - block_cnt[N][BLOCK_CNT_BITS]
  - rr_ptr (last granted index)
  - registered outputs
- **Active update:** active_next = (active | set) & ~clr. clr wins when set and clr hit the same bit.
- **Block update:**
  - When block_valid && block_cycles != 0, block_cnt[block_thread_index] loads block_cycles. This overwrites any count in progress.
  - Every other nonzero counter decrements by 1 per edge.
  - A counter is never decremented on the edge it is loaded.
  - Blocking an inactive thread still loads its counter.
- **Eligibility for the selection at edge t:** elig = active & (block_cnt == 0) & ~clr_vec & ~block_vec.
  - block_vec is the one-hot of block_thread_index, qualified by block_valid && block_cycles != 0.
  - A clear or block requested in cycle t therefore excludes the thread from the selection made at edge t.
  - A set in cycle t only takes effect from edge t+1.
- **Arbitration:** the first eligible thread searching from (rr_ptr+1) mod N upward, wrapping.
- **Update at edge t, when fetch_stall == 0:**
  - If any thread is eligible: out_fetch_valid=1, out_thread_index=winner, rr_ptr=winner.
  - If none is eligible: out_fetch_valid=0, out_thread_index and rr_ptr hold.
- **fetch_stall == 1:**
  - out_fetch_valid, out_thread_index and rr_ptr hold.
  - The held selection is not revoked even if that thread is cleared or blocked during the stall.
  - Active and block updates proceed normally.
- **Reset values:**
  - active_mask = RESET_ACTIVE_MASK
  - all block_cnt = 0
  - rr_ptr = NUM_THREADS-1, so thread 0 wins first
  - out_fetch_valid = 0
  - out_thread_index = 0
  - Reset overrides all inputs on the same edge.

## Timing
- Selection latency is one cycle: the inputs of cycle t determine the outputs after edge t.
- **Block of K issued in cycle t:**
  - The counter is K after edge t and reaches 0 after edge t+K.
  - The thread is excluded from selections at edges t..t+K.
  - The earliest regrant is at edge t+K+1.
- With all N threads eligible, each thread is granted exactly once per N consecutive unstalled cycles.
- A single eligible thread is granted every unstalled cycle.
- There is no combinational path from inputs to out_fetch_valid, out_thread_index or out_active_mask.
- out_ready_mask is combinational from state only.

## Structure
- Shared package `thread_pkg`:
  - NUM_THREADS and THREAD_INDEX_BITS constants
  - thread_mask_t (logic [NUM_THREADS-1:0])
  - thread_idx_t
- Sub-module `rr_priority_picker`:
  - Combinational rotate-by-(ptr+1), priority-encode, un-rotate.
  - Inputs: req mask, ptr. Outputs: grant_valid, grant_index.
  - Reusable by other thread arbiters.

## Test plan
- **Reset, default mask 8'h01, no other inputs:** cycle 1 after reset gives valid=1, index=0, repeating every cycle. out_active_mask=8'h01.
- **set=8'hFF for one cycle, then idle:** the grant sequence is 0,1,2,…,7,0,… with no skips.
  - Then clr=8'h10 in cycle t: no grant of thread 4 at edge t or later.
  - The sequence continues 5,6,7,0,… without thread 4.
- **Threads {0,1} active; block thread 1 with K=3 in cycle t:**
  - Thread 1 is absent at edges t..t+3.
  - Thread 1 is granted at edge t+4, given round-robin position.
  - Reblocking with K=5 at t+1 moves the earliest regrant to edge t+7.
- **All threads blocked or inactive:** valid=0 and index holds. When a counter expires, that thread is granted on the next edge.
- **fetch_stall high for 3 cycles mid-sequence (current index 2):**
  - Index stays 2 and valid stays 1 throughout.
  - After release the next grant is 3.
  - A block on thread 5 with K=2 issued during the stall expires on schedule.
- **Simultaneous set and clr of thread 3, and reset asserted mid-block:**
  - Thread 3 stays inactive.
  - Reset restores mask 8'h01, clears counters, and gives valid=0 on the reset edge.
